// File: rtl/conv_layer_pkg.sv
// -----------------------------------------------------------------------------
// conv_layer_pkg
// Shared constants and encodings for the convolution layer datapath.
//   WIDTH       : pixel / feature word width
//   ARRAY_SIZE  : lanes per kernel-array result bus
//   IMAGE_SIZE  : input image edge
//   KERNEL_SIZE : kernel edge
//   OUT_SIZE    : output feature-map edge (IMAGE_SIZE - KERNEL_SIZE + 1)
// The output stage FSM literals carry an OUT_ prefix so they never collide
// with the input-interface stage encodings living in the same layer.
// -----------------------------------------------------------------------------
package conv_layer_pkg;

    localparam int WIDTH       = 32;
    localparam int ARRAY_SIZE  = 6;
    localparam int IMAGE_SIZE  = 8;
    localparam int KERNEL_SIZE = 3;
    localparam int OUT_SIZE    = IMAGE_SIZE - KERNEL_SIZE + 1;

    // Serializer states of the output interface.
    typedef enum logic {
        OUT_IDLE  = 1'b0,
        OUT_SHIFT = 1'b1
    } out_state_t;

endpackage

// File: rtl/conv_out_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// conv_out_pingpong_buffer
// Two-entry row buffer between the kernel array and the output serializer.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   i_push         : write i_row into the entry at the write pointer
//   i_row          : ARRAY_SIZE*WIDTH row of results
//   i_pop          : free the entry at the read pointer
//   o_full         : both entries occupied
//   o_empty        : no entry occupied
//   o_rd_row       : contents of the entry at the read pointer
// The caller never pushes while full nor pops while empty. A push and a pop in
// the same cycle leave the occupancy unchanged while both pointers advance.
// -----------------------------------------------------------------------------
module conv_out_pingpong_buffer #(
    parameter int WIDTH      = conv_layer_pkg::WIDTH,
    parameter int ARRAY_SIZE = conv_layer_pkg::ARRAY_SIZE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [ARRAY_SIZE*WIDTH-1:0]   i_row,
    input  logic                          i_pop,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [ARRAY_SIZE*WIDTH-1:0]   o_rd_row
);

    logic [ARRAY_SIZE*WIDTH-1:0] r_mem [2];
    logic                        r_wr_ptr;
    logic                        r_rd_ptr;
    logic [1:0]                  r_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_row;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_full   = (r_occ == 2'd2);
    assign o_empty  = (r_occ == 2'd0);
    assign o_rd_row = r_mem[r_rd_ptr];

endmodule

// File: rtl/conv_layer_output_interface.sv
// -----------------------------------------------------------------------------
// conv_layer_output_interface
// Captures parallel rows of kernel-array results into a ping-pong buffer and
// serializes them lane by lane onto one feature stream with RAM write address.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   i_pixel_bus       : row of ARRAY_SIZE results, lane k at [k*WIDTH +: WIDTH]
//   i_bus_valid       : i_pixel_bus holds a row
//   o_bus_ready       : a row can be accepted this cycle
//   o_feature         : serialized word (ReLU applied when RELU_EN)
//   o_feature_valid   : o_feature / o_ram_addr valid
//   i_feature_ready   : downstream takes the word
//   o_ram_addr        : row*OUT_SIZE + lane
//   o_frame_done      : one-cycle pulse after the last word of a map is taken
// Handshake: a row moves when i_bus_valid && o_bus_ready on a rising edge; a
// word moves when o_feature_valid && i_feature_ready on a rising edge. While
// o_feature_valid is high and i_feature_ready is low, o_feature and
// o_ram_addr do not change. o_bus_ready depends only on registered occupancy.
// -----------------------------------------------------------------------------
module conv_layer_output_interface #(
    parameter int WIDTH       = conv_layer_pkg::WIDTH,
    parameter int ARRAY_SIZE  = conv_layer_pkg::ARRAY_SIZE,
    parameter int IMAGE_SIZE  = conv_layer_pkg::IMAGE_SIZE,
    parameter int KERNEL_SIZE = conv_layer_pkg::KERNEL_SIZE,
    parameter int OUT_SIZE    = IMAGE_SIZE - KERNEL_SIZE + 1,
    parameter int ADDR_W      = 6,
    parameter bit RELU_EN     = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ARRAY_SIZE*WIDTH-1:0]   i_pixel_bus,
    input  logic                          i_bus_valid,
    output logic                          o_bus_ready,
    output logic [WIDTH-1:0]              o_feature,
    output logic                          o_feature_valid,
    input  logic                          i_feature_ready,
    output logic [ADDR_W-1:0]             o_ram_addr,
    output logic                          o_frame_done
);

    localparam int LANE_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int ROW_W  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    conv_layer_pkg::out_state_t  r_state;
    logic [LANE_W-1:0]           r_lane_cnt;
    logic [ROW_W-1:0]            r_row_cnt;
    logic                        r_frame_done;

    logic                        w_push;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_hs;
    logic                        w_last_lane;
    logic                        w_last_row;
    logic [ARRAY_SIZE*WIDTH-1:0] w_rd_row;
    logic [WIDTH-1:0]            w_lanes [ARRAY_SIZE];
    logic [WIDTH-1:0]            w_word;

    conv_out_pingpong_buffer #(
        .WIDTH      (WIDTH),
        .ARRAY_SIZE (ARRAY_SIZE)
    ) u_buffer (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_push),
        .i_row    (i_pixel_bus),
        .i_pop    (w_pop),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_rd_row (w_rd_row)
    );

    assign o_bus_ready     = ~w_full;
    assign w_push          = i_bus_valid & ~w_full;
    assign o_feature_valid = (r_state == conv_layer_pkg::OUT_SHIFT);
    assign w_hs            = o_feature_valid & i_feature_ready;
    assign w_last_lane     = (r_lane_cnt == LANE_W'(ARRAY_SIZE - 1));
    assign w_last_row      = (r_row_cnt == ROW_W'(OUT_SIZE - 1));
    assign w_pop           = w_hs & w_last_lane & ~w_empty;

    // The state mirrors "occupancy > 0" after every edge: it enters SHIFT on
    // the same edge that writes the first row, so lane 0 shows one cycle after
    // the row is accepted, and it only leaves SHIFT when the last entry is
    // freed with no new row arriving on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= conv_layer_pkg::OUT_IDLE;
            r_lane_cnt   <= '0;
            r_row_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                conv_layer_pkg::OUT_IDLE: begin
                    if (w_push) begin
                        r_state <= conv_layer_pkg::OUT_SHIFT;
                    end
                end
                conv_layer_pkg::OUT_SHIFT: begin
                    if (w_hs) begin
                        r_lane_cnt <= w_last_lane ? '0 : r_lane_cnt + 1'b1;
                    end
                    if (w_pop) begin
                        if (w_last_row) begin
                            r_row_cnt    <= '0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_row_cnt <= r_row_cnt + 1'b1;
                        end
                        if (!w_full && !w_push) begin
                            r_state <= conv_layer_pkg::OUT_IDLE;
                        end
                    end
                end
                default: r_state <= conv_layer_pkg::OUT_IDLE;
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < ARRAY_SIZE; g++) begin : g_lane
            assign w_lanes[g] = w_rd_row[g*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_word = w_lanes[r_lane_cnt];

    // Word is forced to zero when idle so the stream reads 0 after reset.
    always_comb begin
        o_feature = '0;
        if (o_feature_valid && !(RELU_EN && w_word[WIDTH-1])) begin
            o_feature = w_word;
        end
    end

    assign o_ram_addr   = ADDR_W'(r_row_cnt) * ADDR_W'(OUT_SIZE) + ADDR_W'(r_lane_cnt);
    assign o_frame_done = r_frame_done;

endmodule
